// File: rtl/display_dma_pixel_aligner.sv
// display_dma_pixel_aligner: buffers PPC-pixel DMA words, aligns them to external video timing and unpacks to 1 pixel/clock RGB24.
// Optional colour bars are enabled by defining DISPLAY_DMA_PIXEL_ALIGNER_TESTPATTERN_EN.
module display_dma_pixel_aligner #(
  parameter int PPC = 2,
  parameter int FIFO_DEPTH = 4096,
  parameter int START_LEVEL = 2048,
  parameter int READY_MARGIN = 300,
  parameter logic [23:0] PAD_COLOR = 24'hFFFFFF,
  parameter int BAR_WIDTH = 240
) (
  input  logic                iHdmiClk,
  input  logic                iRst,
  input  logic [PPC*32-1:0]   ivDmaData,
  input  logic                iDmaValid,
  input  logic [PPC*4-1:0]    ivDmaKeep,
  input  logic                iDmaSof,
  output logic                oDmaReady,
  input  logic                iVs,
  input  logic                iHs,
  input  logic                iDe,
  input  logic                iTestPattern,
  input  logic                iClrStatus,
  output logic                oVs,
  output logic                oHs,
  output logic                oDe,
  output logic [23:0]         ov24Rgb,
  output logic                oUnderflow,
  output logic                oOverflow,
  output logic [15:0]         ov16ResyncCount
);
  localparam int W = PPC * 32;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = PPC > 1 ? $clog2(PPC) : 1;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] START_LVL = (AW+1)'(START_LEVEL);
  localparam logic [AW:0] READY_LVL = (AW+1)'(FIFO_DEPTH - READY_MARGIN);
  typedef enum logic [2:0] {WAIT_FILL, ALIGN, WAIT_VS, RUN, RECOVER} stateType;
  stateType state;
  logic [W:0] fifoMem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0] count;
  logic [W:0] head;
  logic headSof, empty, full, push, wrEn, pop, rdEn;
  logic [PW-1:0] p;
  logic firstPix, vsPrev, vsFall, lastSlot, runErr, runOk;
  logic [23:0] slotRgb, runRgb, pixRgb;
  logic vs1, hs1, de1;
  logic [23:0] rgb1;
  assign head = fifoMem[rdPtr];
  assign headSof = head[W];
  assign empty = count == '0;
  assign full = count == FULL_LVL;
  assign push = iDmaValid & oDmaReady & (&ivDmaKeep);
  assign wrEn = push & ~full;
  assign vsFall = vsPrev & ~iVs;
  assign lastSlot = p == PW'(PPC - 1);
  assign slotRgb = head[32*p +: 24];
  // A frame must open on a sof word and no sof word may appear inside it.
  assign runErr = empty | (firstPix & ~headSof) | (~firstPix & headSof & (p == '0));
  assign runOk = (state == RUN) & ~vsFall & iDe & ~runErr;
  assign runRgb = runOk ? slotRgb : PAD_COLOR;
  assign pop = (state == ALIGN) ? ~headSof : (state == RUN) & (vsFall ? (p != '0) : runOk & lastSlot);
  assign rdEn = pop & ~empty;
`ifdef DISPLAY_DMA_PIXEL_ALIGNER_TESTPATTERN_EN
  logic [15:0] barCnt;
  logic [2:0] barIdx;
  always_ff @(posedge iHdmiClk)
    if (iRst | ~iDe) begin
      barCnt <= '0;
      barIdx <= '0;
    end else if (barCnt == 16'(BAR_WIDTH - 1)) begin
      barCnt <= '0;
      barIdx <= barIdx + 3'd1;
    end else
      barCnt <= barCnt + 16'd1;
  assign pixRgb = iTestPattern ? {{8{~barIdx[0]}}, {8{~barIdx[2]}}, {8{~barIdx[1]}}} : runRgb;
`else
  logic unusedTestPattern;
  assign unusedTestPattern = iTestPattern ^ (BAR_WIDTH == 0);
  assign pixRgb = runRgb;
`endif
  always_ff @(posedge iHdmiClk)
    if (wrEn) fifoMem[wrPtr] <= {iDmaSof, ivDmaData};
  always_ff @(posedge iHdmiClk)
    if (iRst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      oDmaReady <= 1'b0;
    end else begin
      wrPtr <= wrPtr + AW'(wrEn);
      rdPtr <= rdPtr + AW'(rdEn);
      count <= count + (AW+1)'(wrEn) - (AW+1)'(rdEn);
      oDmaReady <= count < READY_LVL;
    end
  always_ff @(posedge iHdmiClk)
    if (iRst) begin
      state <= WAIT_FILL;
      p <= '0;
      firstPix <= 1'b0;
    end else
      case (state)
        WAIT_FILL: if (count >= START_LVL) state <= ALIGN;
        ALIGN: if (~empty & headSof) state <= WAIT_VS;
        WAIT_VS:
          if (vsFall) begin
            p <= '0;
            firstPix <= 1'b1;
            state <= RUN;
          end
        RUN:
          if (vsFall) begin
            p <= '0;
            firstPix <= 1'b1;
          end else if (iDe & runErr)
            state <= RECOVER;
          else if (iDe) begin
            p <= lastSlot ? '0 : p + PW'(1);
            firstPix <= 1'b0;
          end
        RECOVER: if (vsFall) state <= ALIGN;
        default: state <= WAIT_FILL;
      endcase
  always_ff @(posedge iHdmiClk)
    if (iRst | iClrStatus) begin
      oUnderflow <= 1'b0;
      oOverflow <= 1'b0;
      ov16ResyncCount <= '0;
    end else begin
      if (push & full) oOverflow <= 1'b1;
      if ((state == RUN) & ~vsFall & iDe & empty) oUnderflow <= 1'b1;
      if ((state == RECOVER) & vsFall & (ov16ResyncCount != 16'hFFFF)) ov16ResyncCount <= ov16ResyncCount + 16'd1;
    end
  always_ff @(posedge iHdmiClk)
    if (iRst) begin
      vsPrev <= 1'b1;
      vs1 <= 1'b1;
      hs1 <= 1'b1;
      de1 <= 1'b0;
      rgb1 <= '0;
      oVs <= 1'b1;
      oHs <= 1'b1;
      oDe <= 1'b0;
      ov24Rgb <= '0;
    end else begin
      vsPrev <= iVs;
      vs1 <= iVs;
      hs1 <= iHs;
      de1 <= iDe;
      rgb1 <= iDe ? pixRgb : '0;
      oVs <= vs1;
      oHs <= hs1;
      oDe <= de1;
      ov24Rgb <= rgb1;
    end
endmodule

// File: tb/tb_display_dma_pixel_aligner.sv
// tb_display_dma_pixel_aligner: scoreboard bench for the DMA pixel aligner with a reduced FIFO.
module tb_display_dma_pixel_aligner;
  localparam logic [23:0] PAD = 24'hFFFFFF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] dmaData = '0;
  logic dmaValid = 1'b0;
  logic [7:0] dmaKeep = 8'hFF;
  logic dmaSof = 1'b0;
  logic dmaReady;
  logic vs = 1'b1, hs = 1'b1, de = 1'b0, tp = 1'b0, clr = 1'b0;
  logic oVs, oHs, oDe, und, ovf;
  logic [23:0] rgb;
  logic [15:0] rcnt;
  int nCmp = 0, nErr = 0;
  logic [23:0] expQ [$];
  logic [2:0] h1 = 3'b110, h2 = 3'b110;
  always #5 clk = ~clk;
  display_dma_pixel_aligner #(
    .PPC(2), .FIFO_DEPTH(64), .START_LEVEL(32), .READY_MARGIN(8), .PAD_COLOR(PAD), .BAR_WIDTH(4)
  ) dut (
    .iHdmiClk(clk), .iRst(rst), .ivDmaData(dmaData), .iDmaValid(dmaValid), .ivDmaKeep(dmaKeep),
    .iDmaSof(dmaSof), .oDmaReady(dmaReady), .iVs(vs), .iHs(hs), .iDe(de), .iTestPattern(tp),
    .iClrStatus(clr), .oVs(oVs), .oHs(oHs), .oDe(oDe), .ov24Rgb(rgb), .oUnderflow(und),
    .oOverflow(ovf), .ov16ResyncCount(rcnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] wordData(input int n);
    logic [7:0] b;
    b = 8'(n);
    return {8'h77, b ^ 8'h5A, 8'h21, b, 8'h77, b ^ 8'hA5, 8'h11, b};
  endfunction
  function automatic logic [23:0] pixOf(input int n, input int k);
    logic [7:0] b;
    b = 8'(n);
    return k == 0 ? {b ^ 8'hA5, 8'h11, b} : {b ^ 8'h5A, 8'h21, b};
  endfunction
  function automatic logic [23:0] barColor(input int idx);
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00, 24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};
    return bars[idx % 8];
  endfunction
  task automatic pushWord(input logic sof, input int n, input logic [7:0] keep);
    int t;
    t = 0;
    dmaData = wordData(n);
    dmaSof = sof;
    dmaKeep = keep;
    dmaValid = 1'b1;
    while (!dmaReady && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) check("pushTimeout", 0, 1);
    tick();
    dmaValid = 1'b0;
  endtask
  // One 8x4 frame; pixels before goodPix come from consecutive words starting at startWord, the rest are pad.
  task automatic runFrame(input int startWord, input int goodPix, input logic bars);
    int i;
    i = 0;
    tick();
    vs = 1'b0;
    tick();
    tick();
    vs = 1'b1;
    tick();
    tick();
    for (int l = 0; l < 4; l++) begin
      hs = 1'b0;
      tick();
      tick();
      hs = 1'b1;
      tick();
      tick();
      for (int x = 0; x < 8; x++) begin
        de = 1'b1;
        expQ.push_back(bars ? barColor(x / 4) : (i < goodPix ? pixOf(startWord + i / 2, i % 2) : PAD));
        tick();
        i++;
      end
      de = 1'b0;
      tick();
      tick();
    end
    repeat (4) tick();
  endtask
  always @(negedge clk) begin
    check("timing", {oVs, oHs, oDe}, h2);
    if (!oDe) check("idleRgb", rgb, 0);
    else if (expQ.size() == 0) check("unexpectedPixel", 1, 0);
    else check("pixel", rgb, expQ.pop_front());
    h2 = h1;
    h1 = {vs, hs, de};
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) tick();
    check("rstReady", dmaReady, 0);
    check("rstVs", oVs, 1);
    check("rstDe", oDe, 0);
    check("rstRgb", rgb, 0);
    check("rstUnd", und, 0);
    check("rstOvf", ovf, 0);
    check("rstCnt", rcnt, 0);
    rst = 1'b0;
    tick();
    tick();
    check("readyUp", dmaReady, 1);
    for (int n = 0; n < 5; n++) pushWord(1'b0, n, 8'hFF);
    for (int n = 5; n < 42; n++) pushWord(n == 5 || n == 21 || n == 37, n, 8'hFF);
    repeat (10) tick();
    runFrame(5, 32, 1'b0);
    runFrame(21, 32, 1'b0);
    runFrame(37, 10, 1'b0);
    check("underflowSet", und, 1);
    check("cntAfterUnderflow", rcnt, 0);
`ifdef DISPLAY_DMA_PIXEL_ALIGNER_TESTPATTERN_EN
    tp = 1'b1;
`endif
    runFrame(0, 0, tp);
    tp = 1'b0;
    check("cntRecover1", rcnt, 1);
    for (int n = 42; n < 58; n++) begin
      pushWord(n == 42, n, 8'hFF);
      if (n == 45) pushWord(1'b0, 999, 8'h7F);
    end
    for (int n = 58; n < 76; n++) pushWord(n == 58 || n == 60, n, 8'hFF);
    repeat (5) tick();
    runFrame(42, 32, 1'b0);
    runFrame(58, 4, 1'b0);
    runFrame(0, 0, 1'b0);
    check("cntRecover2", rcnt, 2);
    runFrame(60, 32, 1'b0);
    check("cntStable", rcnt, 2);
    check("underflowSticky", und, 1);
    check("noOverflow", ovf, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clrUnd", und, 0);
    check("clrCnt", rcnt, 0);
    check("readyBeforeFill", dmaReady, 1);
    for (int j = 0; j < 56; j++) pushWord(1'b0, 100 + j, 8'hFF);
    check("readyLag", dmaReady, 1);
    tick();
    check("readyDrop", dmaReady, 0);
    rst = 1'b1;
    tick();
    check("rstMidReady", dmaReady, 0);
    rst = 1'b0;
    tick();
    tick();
    check("readyAfterFlush", dmaReady, 1);
    repeat (4) tick();
    check("scoreboardDrained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
